// File: rtl/a2d_round_robin_pkg.sv
// Shared eBike acquisition types and constants.
// Channel map, SPI divider preload and A2D sequencer states.
package ebike_pkg;

  localparam logic [2:0] CH_BATT   = 3'd0;
  localparam logic [2:0] CH_CURR   = 3'd1;
  localparam logic [2:0] CH_BRAKE  = 3'd3;
  localparam logic [2:0] CH_TORQUE = 3'd4;

  localparam logic [4:0] SCLK_LOAD = 5'b10111;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    GAP,
    READ
  } a2d_state_t;

  // Round-robin slot to ADC channel number.
  function automatic logic [2:0] slot_chnl(input logic [1:0] slot);
    logic [2:0] ch;
    case (slot)
      2'd0:    ch = CH_BATT;
      2'd1:    ch = CH_CURR;
      2'd2:    ch = CH_BRAKE;
      default: ch = CH_TORQUE;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/a2d_round_robin_if.sv
// SPI bus between the A2D sequencer and the external ADC.
// Master drives select/clock/data out, slave returns MISO.
interface a2d_round_robin_if;

  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO
  );

endinterface

// File: rtl/a2d_round_robin_spi.sv
// Generic 16-bit SPI monarch, mode 3, MSB first.
// SCLK period is 32 clocks; done rises 520 edges after wrt.
module spi_mnrch
  import ebike_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  logic        active;
  logic [4:0]  sclk_div;
  logic [4:0]  smpl_cnt;
  logic [15:0] shft;
  logic        smpl_bit;
  logic        smpl;
  logic        shift;
  logic        last;

  // Sample just before a rise; shift on falls once the
  // first bit has been sampled; finish after 16 samples.
  assign smpl  = active && (sclk_div == 5'b01111);
  assign shift = active && (sclk_div == 5'b11111)
              && (smpl_cnt != 5'd0);
  assign last  = active && (sclk_div == 5'b11110)
              && (smpl_cnt == 5'd16);

  assign SCLK    = sclk_div[4];
  assign MOSI    = shft[15];
  assign rd_data = shft;

  // Transaction engine: divider, bit counter, shifter, select.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      sclk_div <= 5'b11111;
      smpl_cnt <= 5'd0;
      shft     <= 16'h0000;
      smpl_bit <= 1'b0;
      done     <= 1'b0;
      SS_n     <= 1'b1;
    end else if (wrt && !active) begin
      active   <= 1'b1;
      sclk_div <= SCLK_LOAD;
      smpl_cnt <= 5'd0;
      shft     <= wt_data;
      done     <= 1'b0;
      SS_n     <= 1'b0;
    end else if (active) begin
      sclk_div <= sclk_div + 5'd1;
      if (last) begin
        active <= 1'b0;
        shft   <= {shft[14:0], smpl_bit};
        done   <= 1'b1;
        SS_n   <= 1'b1;
      end else begin
        if (smpl) begin
          smpl_bit <= MISO;
          smpl_cnt <= smpl_cnt + 5'd1;
        end
        if (shift) begin
          shft <= {shft[14:0], smpl_bit};
        end
      end
    end
  end

endmodule

// File: rtl/a2d_round_robin.sv
// Round-robin ADC sequencer for batt/curr/brake/torque.
// Each conversion is a command frame then a read frame.
module a2d_round_robin
  import ebike_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  a2d_round_robin_if.master spi,
  output logic [11:0]       batt,
  output logic [11:0]       curr,
  output logic [11:0]       brake,
  output logic [11:0]       torque,
  output logic              cnv_cmplt
);

  a2d_state_t  state;
  a2d_state_t  state_nxt;
  logic [13:0] tmr;
  logic [1:0]  rr;
  logic        trig;
  logic        wrt;
  logic [15:0] wt_data;
  logic        done;
  logic [15:0] rd_data;
  logic        ld;
  logic        unused_rd;

  // Upper nibble of a returned ADC frame carries no data.
  assign unused_rd = ^rd_data[15:12];

  assign trig = FAST_SIM ? (&tmr[9:0]) : (&tmr);

  spi_mnrch u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .wt_data (wt_data),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (spi.SS_n),
    .SCLK    (spi.SCLK),
    .MOSI    (spi.MOSI),
    .MISO    (spi.MISO)
  );

  // Free-running conversion timer, cleared on trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= 14'd0;
    end else if (trig) begin
      tmr <= 14'd0;
    end else begin
      tmr <= tmr + 14'd1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: command frame, one idle gap, read frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (trig) state_nxt = CMD;
      CMD:  if (done) state_nxt = GAP;
      GAP:  state_nxt = READ;
      READ: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame launches and result load strobe.
  always_comb begin
    wrt     = 1'b0;
    wt_data = 16'h0000;
    ld      = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          wrt     = 1'b1;
          wt_data = {2'b00, slot_chnl(rr), 11'h000};
        end
      end
      GAP: begin
        wrt = 1'b1;
      end
      READ: begin
        ld = done;
      end
      default: begin
        wrt = 1'b0;
      end
    endcase
  end

  // Result registers, slot index and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      batt      <= 12'h000;
      curr      <= 12'h000;
      brake     <= 12'h000;
      torque    <= 12'h000;
      rr        <= 2'd0;
      cnv_cmplt <= 1'b0;
    end else begin
      cnv_cmplt <= ld;
      if (ld) begin
        rr <= rr + 2'd1;
        case (rr)
          2'd0:    batt   <= rd_data[11:0];
          2'd1:    curr   <= rd_data[11:0];
          2'd2:    brake  <= rd_data[11:0];
          default: torque <= rd_data[11:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a2d_round_robin.sv
// Bench for a2d_round_robin and its SPI monarch.
// ADC model plus per-cycle scoreboard of the result registers.
module tb_a2d_round_robin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] batt, curr, brake, torque;
  logic        cnv_cmplt;

  always #5 clk = ~clk;

  a2d_round_robin_if bus ();

  a2d_round_robin #(.FAST_SIM(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (bus.master),
    .batt      (batt),
    .curr      (curr),
    .brake     (brake),
    .torque    (torque),
    .cnv_cmplt (cnv_cmplt)
  );

  logic        s_rst = 1'b1;
  logic        s_wrt = 1'b0;
  logic [15:0] s_wdata = 16'h0000;
  logic        s_done, s_ss, s_sclk, s_mosi, s_miso;
  logic [15:0] s_rd;

  spi_mnrch u_spi (
    .clk     (clk),
    .rst     (s_rst),
    .wrt     (s_wrt),
    .wt_data (s_wdata),
    .done    (s_done),
    .rd_data (s_rd),
    .SS_n    (s_ss),
    .SCLK    (s_sclk),
    .MOSI    (s_mosi),
    .MISO    (s_miso)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    chk_cnt++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  always @(posedge clk) cyc++;

  // ---- ADC model for the top-level bus ----
  logic [11:0] val [8];
  int          chmap [4] = '{0, 1, 3, 4};
  int          rise_n = 0;
  int          prev_ch = 0;
  int          tx_n = 0;
  logic [15:0] miso_word = 16'h0000;
  logic [15:0] mosi_word = 16'h0000;
  logic [15:0] exp_word;
  logic [11:0] served = 12'h000;
  logic [15:0] cmd_log [$];

  assign bus.MISO = (rise_n < 16) ? miso_word[4'(15 - rise_n)] : 1'b0;

  always @(negedge bus.SS_n) begin
    rise_n    = 0;
    mosi_word = 16'h0000;
    miso_word = {4'h0, val[prev_ch]};
  end

  always @(posedge bus.SCLK) begin
    if (!bus.SS_n) begin
      mosi_word = {mosi_word[14:0], bus.MOSI};
      rise_n++;
    end
  end

  always @(posedge bus.SS_n) begin
    if (rst !== 1'b1) begin
      if (tx_n % 2 == 0)
        exp_word = {2'b00, 3'(chmap[(tx_n / 2) % 4]), 11'h000};
      else
        exp_word = 16'h0000;
      chk("mosi_frame", mosi_word, exp_word);
      cmd_log.push_back(mosi_word);
      prev_ch = int'(mosi_word[13:11]);
      served  = miso_word[11:0];
      tx_n++;
    end
  end

  // ---- standalone SPI slave model ----
  int          s_rise = 0;
  logic [15:0] s_pat = 16'h3C5A;
  logic [15:0] s_cap = 16'h0000;

  assign s_miso = (s_rise < 16) ? s_pat[4'(15 - s_rise)] : 1'b0;

  always @(negedge s_ss) begin
    s_rise = 0;
    s_cap  = 16'h0000;
  end

  always @(posedge s_sclk) begin
    if (!s_ss) begin
      s_cap = {s_cap[14:0], s_mosi};
      s_rise++;
    end
  end

  // ---- scoreboard: expected results, checked every cycle ----
  logic [11:0] exp_r [4];
  int          rr_m = 0;
  logic        rst_q = 1'b1;
  logic        chk_on = 1'b0;
  logic        prev_c = 1'b0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (rst_q) begin
      foreach (exp_r[i]) exp_r[i] = 12'h000;
      rr_m = 0;
      tx_n = 0;
    end else if (cnv_cmplt) begin
      exp_r[rr_m] = served;
      rr_m = (rr_m + 1) % 4;
    end
    if (chk_on) begin
      chk("batt", batt, exp_r[0]);
      chk("curr", curr, exp_r[1]);
      chk("brake", brake, exp_r[2]);
      chk("torque", torque, exp_r[3]);
      if (cnv_cmplt) chk("cmplt_single", prev_c, 1'b0);
    end
    prev_c = cnv_cmplt;
  end

  // ---- bounded waits ----
  task automatic wait_cmplt(input int lim);
    int n = 0;
    while (n < lim) begin
      @(posedge clk);
      #1;
      n++;
      if (cnv_cmplt) break;
    end
    if (!cnv_cmplt) tmo("wait_cmplt");
  endtask

  task automatic wait_ss(input logic lvl, input int lim);
    int n = 0;
    while (n < lim) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.SS_n == lvl) break;
    end
    if (bus.SS_n != lvl) tmo("wait_ss");
  endtask

  task automatic spi_test();
    int n = 0;
    @(posedge clk);
    #2 s_wdata = 16'hA5C3;
    s_wrt = 1'b1;
    @(posedge clk);
    #1 s_wrt = 1'b0;
    chk("spi_ss_fall", s_ss, 1'b0);
    while (!s_done && n < 700) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 200) begin
        s_wdata = 16'hFFFF;
        s_wrt   = 1'b1;
      end else begin
        s_wrt = 1'b0;
      end
    end
    chk("spi_done_lat", n, 520);
    chk("spi_rd_data", s_rd, 16'h3C5A);
    chk("spi_mosi", s_cap, 16'hA5C3);
    chk("spi_ss_end", s_ss, 1'b1);
    chk("spi_sclk_end", s_sclk, 1'b1);
  endtask

  int t_prev;

  initial begin
    foreach (val[i]) val[i] = 12'h000;
    val[0] = 12'hA98;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss", bus.SS_n, 1'b1);
    chk("rst_sclk", bus.SCLK, 1'b1);
    chk("rst_mosi", bus.MOSI, 1'b0);
    chk("rst_cmplt", cnv_cmplt, 1'b0);
    chk("rst_batt", batt, 12'h000);
    chk("rst_torque", torque, 12'h000);
    @(posedge clk);
    #2 rst = 1'b0;
    s_rst  = 1'b0;
    chk_on = 1'b1;

    spi_test();

    wait_cmplt(3000);
    t_prev = cyc;
    chk("first_batt", batt, 12'hA98);
    chk("first_curr", curr, 12'h000);
    chk("first_brake", brake, 12'h000);
    chk("first_torque", torque, 12'h000);

    val[0] = 12'h111;
    val[1] = 12'h222;
    val[3] = 12'h333;
    val[4] = 12'h444;
    repeat (4) begin
      wait_cmplt(2200);
      chk("period", cyc - t_prev, 2048);
      t_prev = cyc;
    end
    chk("four_batt", batt, 12'h111);
    chk("four_curr", curr, 12'h222);
    chk("four_brake", brake, 12'h333);
    chk("four_torque", torque, 12'h444);
    if (cmd_log.size() >= 8) begin
      chk("cmd0", cmd_log[0], 16'h0000);
      chk("cmd1", cmd_log[2], 16'h0800);
      chk("cmd3", cmd_log[4], 16'h1800);
      chk("cmd4", cmd_log[6], 16'h2000);
    end else begin
      tmo("cmd_log");
    end

    repeat (6) begin
      foreach (chmap[k]) val[chmap[k]] = 12'($urandom);
      wait_cmplt(2200);
      chk("period", cyc - t_prev, 2048);
      t_prev = cyc;
    end

    wait_ss(1'b0, 2200);
    wait_ss(1'b1, 700);
    wait_ss(1'b0, 10);
    repeat (299) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ss", bus.SS_n, 1'b1);
    chk("abort_sclk", bus.SCLK, 1'b1);
    chk("abort_mosi", bus.MOSI, 1'b0);
    chk("abort_cmplt", cnv_cmplt, 1'b0);
    chk("abort_batt", batt, 12'h000);
    chk("abort_brake", brake, 12'h000);
    @(posedge clk);
    #2 rst = 1'b0;

    val[0] = 12'h5E7;
    wait_cmplt(2500);
    chk("post_batt", batt, 12'h5E7);
    chk("post_curr", curr, 12'h000);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
